// File: rtl/riscv_v_vcfg_if.sv
// Shared CSR types and the vset* request/response interface of the vector
// configuration unit.
package riscv_v_vcfg_pkg;
    // Architectural vtype fields; reserved bits are always zero once normalised.
    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } riscv_v_vtype_t;

    // Sized for the largest architectural VLEN (65536): vl <= VLEN, vstart < VLEN.
    typedef logic [16:0] riscv_v_vl_t;
    typedef logic [15:0] riscv_v_vstart_t;
endpackage

// vset* request/response handshake between the issue stage and the unit.
interface riscv_v_vcfg_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic            req_rs1_is_x0;
    logic            req_rd_is_x0;
    logic [XLEN-1:0] req_avl;
    logic [XLEN-1:0] req_vtype;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_vl;

    modport master (
        output req_valid, req_op, req_rs1_is_x0, req_rd_is_x0, req_avl, req_vtype,
        input  req_ready, rsp_valid, rsp_vl
    );

    modport slave (
        input  req_valid, req_op, req_rs1_is_x0, req_rd_is_x0, req_avl, req_vtype,
        output req_ready, rsp_valid, rsp_vl
    );
endinterface

// File: rtl/riscv_v_vcfg.sv
// Vector configuration-state unit: holds vtype/vl/vstart and executes
// vsetvli/vsetivli/vsetvl as a three-state IDLE -> CALC -> COMMIT sequence.
module riscv_v_vcfg
    import riscv_v_vcfg_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 64,
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_v_vcfg_if.slave         bus,
    input  logic                  vstart_we,
    input  logic [XLEN-1:0]       vstart_wdata,
    input  logic                  vinstr_done,
    output riscv_v_vtype_t        vtype,
    output riscv_v_vl_t           vl,
    output riscv_v_vstart_t       vstart,
    output logic                  busy
);
    localparam int VSW = $clog2(VLEN);
    localparam int VLW = VSW + 1;
    localparam logic [VLW-1:0] VLEN_W = VLW'(VLEN);
    localparam logic [10:0]    ELEN_W = 11'(ELEN);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            rs1_x0_q, rs1_x0_d;
    logic            rd_x0_q, rd_x0_d;
    logic [XLEN-1:0] avl_q, avl_d;
    logic [XLEN-1:0] raw_q, raw_d;
    riscv_v_vtype_t  cfg_vtype_q, cfg_vtype_d;
    logic [VLW-1:0]  cfg_vl_q, cfg_vl_d;
    riscv_v_vtype_t  vtype_q, vtype_d;
    logic [VLW-1:0]  vl_q, vl_d;
    logic [VSW-1:0]  vstart_q, vstart_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_vl_q, rsp_vl_d;

    logic [2:0]      vsew, vlmul, lmul_neg;
    logic [10:0]     sew;
    logic            lmul_frac, vill;
    logic [VLW-1:0]  vlmax_base, vlmax;
    logic [XLEN-1:0] avl_sel, vlmax_x, new_vl_x;
    logic [VLW-1:0]  new_vl;

    // Decode the latched raw vtype and derive VLMAX and the new vl.
    always_comb begin
        vsew       = raw_q[5:3];
        vlmul      = raw_q[2:0];
        lmul_frac  = vlmul[2];
        lmul_neg   = 3'd0 - vlmul;
        sew        = 11'd8 << vsew;
        vill       = (vlmul == 3'd4) || (sew > ELEN_W) ||
                     (lmul_frac && (sew > (ELEN_W >> lmul_neg))) ||
                     (|raw_q[XLEN-2:8]);
        vlmax_base = VLEN_W >> ({1'b0, vsew} + 4'd3);
        if (vill) begin
            vlmax = '0;
        end else if (lmul_frac) begin
            vlmax = vlmax_base >> lmul_neg;
        end else begin
            vlmax = vlmax_base << vlmul;
        end

        if (op_q == 2'd1) begin
            avl_sel = {{(XLEN-5){1'b0}}, avl_q[4:0]};
        end else if (!rs1_x0_q) begin
            avl_sel = avl_q;
        end else if (!rd_x0_q) begin
            avl_sel = '1;
        end else begin
            avl_sel = {{(XLEN-VLW){1'b0}}, vl_q};
        end

        vlmax_x  = {{(XLEN-VLW){1'b0}}, vlmax};
        new_vl_x = (avl_sel < vlmax_x) ? avl_sel : vlmax_x;
        new_vl   = new_vl_x[VLW-1:0];
    end

    // Next-state logic for the FSM, the CSRs and the response.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs1_x0_d    = rs1_x0_q;
        rd_x0_d     = rd_x0_q;
        avl_d       = avl_q;
        raw_d       = raw_q;
        cfg_vtype_d = cfg_vtype_q;
        cfg_vl_d    = cfg_vl_q;
        vtype_d     = vtype_q;
        vl_d        = vl_q;
        rsp_valid_d = 1'b0;
        rsp_vl_d    = rsp_vl_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    rs1_x0_d = bus.req_rs1_is_x0;
                    rd_x0_d  = bus.req_rd_is_x0;
                    avl_d    = bus.req_avl;
                    raw_d    = bus.req_vtype;
                    state_d  = CALC;
                end
            end
            CALC: begin
                cfg_vtype_d = vill ? riscv_v_vtype_t'(9'h100)
                                   : riscv_v_vtype_t'({1'b0, raw_q[7:0]});
                cfg_vl_d    = new_vl;
                state_d     = COMMIT;
            end
            COMMIT: begin
                vtype_d     = cfg_vtype_q;
                vl_d        = cfg_vl_q;
                rsp_valid_d = 1'b1;
                rsp_vl_d    = {{(XLEN-VLW){1'b0}}, cfg_vl_q};
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // COMMIT clear beats a CSR write, which beats the retire clear.
        if (state_q == COMMIT) begin
            vstart_d = '0;
        end else if (vstart_we) begin
            vstart_d = vstart_wdata[VSW-1:0];
        end else if (vinstr_done) begin
            vstart_d = '0;
        end else begin
            vstart_d = vstart_q;
        end
    end

    // FSM state, architectural CSRs and response, all reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vtype_q     <= riscv_v_vtype_t'(9'h100);
            vl_q        <= '0;
            vstart_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_vl_q    <= '0;
        end else begin
            state_q     <= state_d;
            vtype_q     <= vtype_d;
            vl_q        <= vl_d;
            vstart_q    <= vstart_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_vl_q    <= rsp_vl_d;
        end
    end

    // Latched request and computed configuration; only read after being loaded.
    always_ff @(posedge clk) begin
        op_q        <= op_d;
        rs1_x0_q    <= rs1_x0_d;
        rd_x0_q     <= rd_x0_d;
        avl_q       <= avl_d;
        raw_q       <= raw_d;
        cfg_vtype_q <= cfg_vtype_d;
        cfg_vl_q    <= cfg_vl_d;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_vl    = rsp_vl_q;
    assign busy          = (state_q != IDLE);
    assign vtype         = vtype_q;
    assign vl            = riscv_v_vl_t'(vl_q);
    assign vstart        = riscv_v_vstart_t'(vstart_q);

    // Bit XLEN-1 of the raw vtype and the upper vstart data bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{raw_q[XLEN-1], vstart_wdata[XLEN-1:VSW]};
endmodule

// File: tb/tb_riscv_v_vcfg.sv
// Randomised bench for riscv_v_vcfg against an arithmetic reference model.
module tb_riscv_v_vcfg;
    import riscv_v_vcfg_pkg::*;

    localparam int VLEN = 128;
    localparam int ELEN = 64;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vstart_we = 1'b0;
    logic [XLEN-1:0] vstart_wdata = '0;
    logic            vinstr_done = 1'b0;
    riscv_v_vtype_t  vtype;
    riscv_v_vl_t     vl;
    riscv_v_vstart_t vstart;
    logic            busy;

    riscv_v_vcfg_if #(.XLEN(XLEN)) bus ();

    riscv_v_vcfg #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .vstart_we    (vstart_we),
        .vstart_wdata (vstart_wdata),
        .vinstr_done  (vinstr_done),
        .vtype        (vtype),
        .vl           (vl),
        .vstart       (vstart),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    longint cur_vl = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: VLMAX = LMUL*VLEN/SEW, vl = min(AVL, VLMAX), illegal configs give vill.
    function automatic void model(input int op, input bit rs1x0, input bit rdx0,
                                  input logic [XLEN-1:0] avl, input logic [XLEN-1:0] vt,
                                  input longint old_vl,
                                  output logic [8:0] evt, output longint evl);
        int     vsew_i;
        int     vlmul_i;
        int     l;
        longint sew_i;
        longint vlmax_i;
        longint a;
        bit     ill;
        vsew_i  = int'(vt[5:3]);
        vlmul_i = int'(vt[2:0]);
        sew_i   = 64'd8 << vsew_i;
        l       = (vlmul_i >= 5) ? vlmul_i - 8 : vlmul_i;
        ill     = (vlmul_i == 4) || (sew_i > ELEN) ||
                  (l < 0 && sew_i * (longint'(1) << (-l)) > ELEN) ||
                  (vt[XLEN-2:8] != 0);
        if (ill)
            vlmax_i = 0;
        else if (l >= 0)
            vlmax_i = (VLEN * (longint'(1) << l)) / sew_i;
        else
            vlmax_i = VLEN / (sew_i * (longint'(1) << (-l)));
        if (op == 1)
            a = longint'(avl[4:0]);
        else if (!rs1x0)
            a = longint'(avl);
        else if (!rdx0)
            a = 64'hFFFF_FFFF;
        else
            a = old_vl;
        evl = (a < vlmax_i) ? a : vlmax_i;
        evt = ill ? 9'h100 : {1'b0, vt[7:0]};
    endfunction

    function automatic logic [XLEN-1:0] mk_vt(input int vma, input int vta, input int vsew_i, input int vlmul_i);
        logic [XLEN-1:0] v;
        v = '0;
        v[7]   = vma[0];
        v[6]   = vta[0];
        v[5:3] = vsew_i[2:0];
        v[2:0] = vlmul_i[2:0];
        return v;
    endfunction

    // Issue one vset* and check every cycle of its timeline; called at a negedge.
    task automatic vset(input int op, input bit rs1x0, input bit rdx0,
                        input logic [XLEN-1:0] avl, input logic [XLEN-1:0] vt,
                        input bit we_in_commit);
        logic [8:0] evt;
        longint     evl;
        int         n;
        model(op, rs1x0, rdx0, avl, vt, cur_vl, evt, evl);
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", 64'(bus.req_ready), 64'd1);
        bus.req_valid     = 1'b1;
        bus.req_op        = op[1:0];
        bus.req_rs1_is_x0 = rs1x0;
        bus.req_rd_is_x0  = rdx0;
        bus.req_avl       = avl;
        bus.req_vtype     = vt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("calc_ready", 64'(bus.req_ready), 64'd0);
        chk("calc_busy", 64'(busy), 64'd1);
        chk("calc_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("commit_ready", 64'(bus.req_ready), 64'd0);
        chk("commit_vl_hold", 64'(vl), 64'(cur_vl));
        if (we_in_commit) begin
            vstart_we    = 1'b1;
            vstart_wdata = 32'd9;
        end
        @(negedge clk);
        vstart_we = 1'b0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_vl", 64'(bus.rsp_vl), 64'(evl));
        chk("vl", 64'(vl), 64'(evl));
        chk("vtype", 64'(vtype), 64'(evt));
        chk("vstart_commit", 64'(vstart), 64'd0);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        cur_vl = evl;
        @(negedge clk);
        chk("rsp_pulse_end", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_op        = 2'd0;
        bus.req_rs1_is_x0 = 1'b0;
        bus.req_rd_is_x0  = 1'b0;
        bus.req_avl       = '0;
        bus.req_vtype     = '0;
        repeat (3) @(negedge clk);
        chk("rst_vtype", 64'(vtype), 64'h100);
        chk("rst_vl", 64'(vl), 64'd0);
        chk("rst_vstart", 64'(vstart), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        vset(0, 0, 0, 32'd20, mk_vt(0, 0, 1, 0), 0);
        chk("dir_vl8", 64'(vl), 64'd8);
        vset(1, 1, 1, 32'd3, mk_vt(1, 1, 2, 1), 0);
        chk("dir_vl3", 64'(vl), 64'd3);
        vset(0, 1, 0, 32'd0, mk_vt(0, 0, 0, 3), 0);
        chk("dir_vl128", 64'(vl), 64'd128);
        vset(0, 1, 1, 32'd0, mk_vt(0, 0, 0, 7), 0);
        chk("dir_frac_vl8", 64'(vl), 64'd8);
        vset(2, 0, 0, 32'd50, mk_vt(1, 1, 4, 0), 0);
        chk("dir_sew128_vl", 64'(vl), 64'd0);
        vset(3, 0, 0, 32'd50, mk_vt(0, 0, 0, 4), 0);
        chk("dir_lmul4_vill", 64'(vtype.vill), 64'd1);
        vset(2, 0, 0, 32'd50, mk_vt(0, 0, 0, 0) | 32'h0000_0100, 0);
        vset(0, 0, 0, 32'd50, mk_vt(0, 0, 3, 5), 0);

        // vstart write paths
        vstart_we = 1'b1; vstart_wdata = 32'd5;
        @(negedge clk);
        vstart_we = 1'b0;
        chk("vstart_we", 64'(vstart), 64'd5);
        vinstr_done = 1'b1; vstart_we = 1'b1; vstart_wdata = 32'h0000_0107;
        @(negedge clk);
        vinstr_done = 1'b0; vstart_we = 1'b0;
        chk("vstart_we_beats_done", 64'(vstart), 64'd7);
        vinstr_done = 1'b1;
        @(negedge clk);
        vinstr_done = 1'b0;
        chk("vstart_done_clear", 64'(vstart), 64'd0);
        vset(0, 0, 0, 32'd17, mk_vt(0, 1, 0, 0), 1);

        // Reset asserted during CALC aborts the request
        vstart_we = 1'b1; vstart_wdata = 32'd6;
        @(negedge clk);
        vstart_we = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_rs1_is_x0 = 1'b0;
        bus.req_rd_is_x0 = 1'b0; bus.req_avl = 32'd9; bus.req_vtype = mk_vt(0, 0, 0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_vtype", 64'(vtype), 64'h100);
        chk("abort_vl", 64'(vl), 64'd0);
        chk("abort_vstart", 64'(vstart), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        rst = 1'b0;
        cur_vl = 0;
        @(negedge clk);
        chk("abort_idle_rsp", 64'(bus.rsp_valid), 64'd0);

        // Randomised vset* traffic
        for (int i = 0; i < 60; i++) begin
            logic [XLEN-1:0] vt;
            logic [XLEN-1:0] avl;
            vt = mk_vt($urandom_range(0, 1), $urandom_range(0, 1),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3),
                       $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) vt[$urandom_range(8, XLEN - 1)] = 1'b1;
            avl = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 140);
            vset($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 avl, vt, 1'($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/riscv_v_vcfg.md
# riscv_v_vcfg

Vector configuration-state unit for the RISC-V V pipeline. It holds the architectural vtype, vl and vstart CSRs, executes vsetvli/vsetivli/vsetvl through a small FSM, and returns the new vl for scalar writeback. Its vtype/vl/vstart outputs drive the decode-element stage directly, which builds element-valid, tail and osize masks from them.

## Interface

Parameters:
- VLEN, 128: bits per vector register.
- ELEN, 64: maximum supported element width in bits.
- XLEN, 32: scalar register width.

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a vset* instruction is presented.
- req_ready  out  1  the unit can accept a request.
- req_op  in  2  0=VSETVLI, 1=VSETIVLI, 2=VSETVL; 3 is reserved and treated as VSETVL.
- req_rs1_is_x0  in  1  rs1 field is x0; ignored for VSETIVLI.
- req_rd_is_x0  in  1  rd field is x0.
- req_avl  in  XLEN  rs1 value, or the zero-extended uimm[4:0] for VSETIVLI.
- req_vtype  in  XLEN  raw vtype: zimm for VSETVLI/VSETIVLI, rs2 value for VSETVL.
- rsp_valid  out  1  one-cycle pulse carrying the rd writeback.
- rsp_vl  out  XLEN  new vl, zero-extended.
- vstart_we  in  1  CSR write to vstart.
- vstart_wdata  in  XLEN  vstart write data; the low $clog2(VLEN) bits are kept.
- vinstr_done  in  1  a vector instruction retired; clears vstart.
- vtype  out  riscv_v_vtype_t  current vtype.
- vl  out  riscv_v_vl_t  current vl.
- vstart  out  riscv_v_vstart_t  current vstart.
- busy  out  1  FSM is not in IDLE.

## Operation

FSM states:
- IDLE: req_ready=1. When req_valid is high, latch op, flags, avl and vtype, then go to CALC.
- CALC: decode the latched vtype, compute VLMAX and the new vl into registers, then go to COMMIT.
- COMMIT: write vtype and vl, clear vstart to 0, pulse rsp_valid, drive rsp_vl, return to IDLE.

req_ready is 0 in CALC and COMMIT. There is no response backpressure.

Field decode:
- vsew = vtype[5:3]; SEW = 8<<vsew.
- vlmul = vtype[2:0], read as a signed LMUL exponent L: 0..3 map to L=0..3, 5/6/7 map to L=-3/-2/-1.
- vta = bit 6, vma = bit 7.

vill is set when any of these holds:
- vlmul == 4.
- SEW > ELEN.
- L < 0 and SEW > ELEN>>(-L).
- Any of bits [XLEN-2:8] is nonzero.

When vill is set, vtype becomes {vill=1, all other fields 0} and vl becomes 0.

VLMAX arithmetic: VLMAX = (VLEN>>(vsew+3)) shifted left by L, or right by -L when L is negative, computed at $clog2(VLEN)+1 bits. VLMAX is 0 only when vill is set.

AVL selection:
- VSETIVLI: AVL = req_avl[4:0].
- rs1 != x0: AVL = req_avl.
- rs1 == x0 and rd != x0: AVL = all ones, so vl = VLMAX.
- rs1 == x0 and rd == x0: AVL = the current vl, so vl = min(old vl, new VLMAX).

New vl = min(AVL, VLMAX), using an unsigned compare at XLEN bits.

vstart update priority, highest first:
1. COMMIT clears vstart to 0.
2. vstart_we loads vstart_wdata.
3. vinstr_done clears vstart to 0.
4. Otherwise vstart holds.

## Timing

- Reset values: state=IDLE, vtype={vill=1, all other fields 0}, vl=0, vstart=0, rsp_valid=0, rsp_vl=0, busy=0, req_ready=1.
- Latency: a request accepted on edge N enters CALC. COMMIT happens on edge N+1. rsp_valid is high and the new vtype/vl are visible during the cycle after edge N+2; rsp_valid returns to 0 one cycle later.
- Throughput: one vset* every 3 cycles. A request held high is accepted again on the first edge after COMMIT.
- vtype and vl change only at COMMIT, so the decode stage never sees a partially updated configuration.
- vstart_we takes effect on the next edge in any state, unless it coincides with COMMIT.
- Reset asserted mid-operation (CALC or COMMIT) aborts the request: no rsp_valid pulse, and all CSRs return to their reset values asynchronously.

## Test plan

- Reset with req_valid=0 -> vtype.vill=1, vl=0, vstart=0, req_ready=1, busy=0.
- VSETVLI, rs1≠x0, AVL=20, vsew=1, vlmul=0 -> VLMAX=8; rsp_valid and vl=8 in the cycle after edge N+2; vill=0; req_ready=0 during CALC/COMMIT.
- VSETIVLI, uimm=3, vsew=2, vlmul=1 -> vl=3. Then VSETVLI with rs1=x0, rd≠x0, vsew=0, vlmul=3 -> vl=128.
- VSETVL with vsew=4 (SEW 128 > ELEN) -> vill=1, vtype fields=0, vl=0, rsp_vl=0. Repeat with vlmul=4 -> same result.
- From vl=128, VSETVLI with rs1=rd=x0, vsew=0, vlmul=7 (LMUL 1/2) -> VLMAX=8, vl=8.
- vstart_we=1, data 5 while in IDLE -> vstart=5. Assert vstart_we in the COMMIT cycle -> vstart=0. vstart_we=1 together with vinstr_done=1 in IDLE -> write wins. Assert rst during CALC -> no rsp_valid, CSRs at reset values.
